// File: rtl/ram8_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed FIFO controller.
package fifo_ctrl_pkg;

  localparam int unsigned DW     = 4;
  localparam int unsigned AW     = 3;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned RD_LAT = 1;

  // level spans 0..DEPTH+1, so one bit beyond the address width is enough.
  function automatic int unsigned level_w(input int unsigned aw);
    return aw + 1;
  endfunction

  typedef enum logic [1:0] {
    RAM_IDLE,
    RAM_WRITE,
    RAM_READ
  } ram_op_e;

endpackage

// File: rtl/ram8_fifo_ctrl_if.sv
// Input and output valid/ready streams of the FIFO controller.
interface ram8_fifo_ctrl_if #(
  parameter int unsigned DW = fifo_ctrl_pkg::DW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/ram8_fifo_ctrl_rd_lat_pipe.sv
// Delays the read-issue strobe by RD_LAT cycles to mark when ram_out is valid.
module rd_lat_pipe #(
  parameter int unsigned RD_LAT = fifo_ctrl_pkg::RD_LAT
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic ret
);

  logic [RD_LAT-1:0] sh;

  generate
    if (RD_LAT == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (reset) sh <= '0;
        else       sh <= issue;
      end
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (reset) sh <= '0;
        else       sh <= {sh[RD_LAT-2:0], issue};
      end
    end
  endgenerate

  assign ret = sh[RD_LAT-1];

endmodule

// File: rtl/ram8_fifo_ctrl.sv
// FIFO controller around a single-port register-file RAM; owns pointers,
// occupancy, read/write arbitration and the registered output word.
module ram8_fifo_ctrl #(
  parameter int unsigned DW     = fifo_ctrl_pkg::DW,
  parameter int unsigned AW     = fifo_ctrl_pkg::AW,
  parameter int unsigned RD_LAT = fifo_ctrl_pkg::RD_LAT
) (
  input  logic                clk,
  input  logic                reset,
  ram8_fifo_ctrl_if.slave     s,
  output logic [AW-1:0]       ram_addr,
  output logic                ram_load,
  output logic [DW-1:0]       ram_in,
  input  logic [DW-1:0]       ram_out,
  output logic [AW:0]         level,
  output logic                full,
  output logic                empty
);

  import fifo_ctrl_pkg::*;

  localparam int unsigned DEPTH   = 1 << AW;
  localparam int unsigned LW      = level_w(AW);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          rd_pending;
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;

  logic    rd_issue;
  logic    rd_ret;
  logic    in_ready_c;
  logic    wr_fire;
  logic    pop;
  ram_op_e ram_op;

  // Reads win the single RAM port; a write waits at most one cycle.
  always_comb begin
    rd_issue   = (count != '0) && !rd_pending && (!out_valid_q || s.out_ready);
    in_ready_c = (count < DEPTH_C) && !rd_issue;
    wr_fire    = s.in_valid && in_ready_c;
    pop        = out_valid_q && s.out_ready;

    ram_op = RAM_IDLE;
    if (rd_issue)     ram_op = RAM_READ;
    else if (wr_fire) ram_op = RAM_WRITE;

    ram_addr = (ram_op == RAM_READ) ? rd_ptr : wr_ptr;
    ram_load = (ram_op == RAM_WRITE);
    ram_in   = s.in_data;
  end

  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_rd_lat_pipe (
    .clk   (clk),
    .reset (reset),
    .issue (rd_issue),
    .ret   (rd_ret)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (rd_issue) begin
        count  <= count - 1'b1;
      end

      if (rd_issue) rd_ptr <= rd_ptr + 1'b1;

      // A return landing on a pop edge replaces the popped word directly.
      if (rd_ret) begin
        out_data_q  <= ram_out;
        out_valid_q <= 1'b1;
        rd_pending  <= 1'b0;
      end else begin
        if (pop)      out_valid_q <= 1'b0;
        if (rd_issue) rd_pending  <= 1'b1;
      end
    end
  end

  assign s.in_ready  = in_ready_c;
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;

  assign level = count + LW'(rd_pending) + LW'(out_valid_q);
  assign full  = (count == DEPTH_C);
  assign empty = (level == '0);

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Scoreboard bench for ram8_fifo_ctrl with a behavioural single-port RAM.
module tb_ram8_fifo_ctrl;

  import fifo_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] ram_addr;
  logic          ram_load;
  logic [DW-1:0] ram_in;
  logic [DW-1:0] ram_out;
  logic [AW:0]   level;
  logic          full;
  logic          empty;

  ram8_fifo_ctrl_if #(.DW(DW)) sif ();

  ram8_fifo_ctrl #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (sif),
    .ram_addr (ram_addr),
    .ram_load (ram_load),
    .ram_in   (ram_in),
    .ram_out  (ram_out),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous write, read data valid RD_LAT cycles after address.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdq [RD_LAT];
  always @(posedge clk) begin
    if (ram_load) mem[ram_addr] <= ram_in;
    rdq[0] <= mem[ram_addr];
    for (int i = 1; i < int'(RD_LAT); i++) rdq[i] <= rdq[i-1];
  end
  assign ram_out = rdq[RD_LAT-1];

  int n_chk  = 0;
  int n_fail = 0;
  logic [DW-1:0] exp_q [$];
  int wr_model = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output handshake pops and compares one expected word.
  always @(negedge clk) begin
    if (!reset && sif.out_valid && sif.out_ready) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected none", sif.out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (sif.out_data !== e) begin
          n_fail++;
          $display("FAIL out_data: got %0h expected %0h at %0t", sif.out_data, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1; retries while the read port has priority.
  task automatic push(input logic [DW-1:0] d);
    bit done = 1'b0;
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    for (int t = 0; t < 50 && !done; t++) begin
      #1;
      if (sif.in_ready) begin
        chk("wr_load", 32'(ram_load), 32'd1);
        chk("wr_addr", 32'(ram_addr), 32'(wr_model % int'(DEPTH)));
        exp_q.push_back(d);
        wr_model++;
        done = 1'b1;
      end
      tick();
    end
    sif.in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (level == '0 && !sif.out_valid) done = 1'b1;
      tick();
    end
    chk("drain_level", 32'(level), 32'd0);
    chk("drain_empty", 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset         = 1'b1;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.out_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    #1;

    // 1: reset, then idle
    repeat (2) tick();
    reset = 1'b0;
    #1;
    chk("rst_in_ready",  32'(sif.in_ready),  32'd1);
    chk("rst_out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst_empty",     32'(empty),         32'd1);
    chk("rst_level",     32'(level),         32'd0);
    chk("rst_ram_load",  32'(ram_load),      32'd0);
    chk("rst_out_data",  32'(sif.out_data),  32'd0);
    tick();

    // 2: first-word latency, then a second word at address 1
    sif.out_ready = 1'b1;
    sif.in_valid  = 1'b1;
    sif.in_data   = 4'hC;
    #1;
    chk("p2_in_ready", 32'(sif.in_ready), 32'd1);
    chk("p2_load",     32'(ram_load),     32'd1);
    chk("p2_addr",     32'(ram_addr),     32'd0);
    exp_q.push_back(4'hC);
    wr_model++;
    tick();
    sif.in_valid = 1'b0;
    n = 1;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (sif.out_valid) break;
      tick();
      n++;
    end
    chk("first_latency", 32'(n), 32'd3);
    tick();
    push(4'hE);
    wait_drain();

    // 3: fill with consumer stalled, then drain
    sif.out_ready = 1'b0;
    for (int d = 1; d <= 9; d++) push(DW'(d));
    repeat (2) tick();
    chk("full_flag",     32'(full),          32'd1);
    chk("full_in_ready", 32'(sif.in_ready),  32'd0);
    chk("full_level",    32'(level),         32'd9);
    chk("full_out_vld",  32'(sif.out_valid), 32'd1);
    chk("full_out_data", 32'(sif.out_data),  32'd1);
    sif.out_ready = 1'b1;
    #1;
    // full means rd_ptr == wr_ptr, so the read addresses the write pointer
    chk("fullpop_in_ready", 32'(sif.in_ready), 32'd0);
    chk("fullpop_load",     32'(ram_load),     32'd0);
    chk("fullpop_addr",     32'(ram_addr),     32'(wr_model % int'(DEPTH)));
    tick();
    wait_drain();

    // 4: wrap both pointers with interleaved traffic
    for (int d = 0; d < 12; d++) push(DW'(d));
    wait_drain();

    // 5: read and write contend for the port in the same cycle
    sif.out_ready = 1'b0;
    push(4'h7); push(4'h8); push(4'h9); push(4'hA);
    repeat (2) tick();
    chk("ct_level", 32'(level), 32'd4);
    sif.out_ready = 1'b1;
    sif.in_valid  = 1'b1;
    sif.in_data   = 4'h4;
    #1;
    chk("ct_in_ready", 32'(sif.in_ready), 32'd0);
    chk("ct_load",     32'(ram_load),     32'd0);
    chk("ct_rd_addr",  32'(ram_addr),     32'((wr_model - 3) % int'(DEPTH)));
    tick();
    #1;
    chk("ct2_in_ready", 32'(sif.in_ready), 32'd1);
    chk("ct2_load",     32'(ram_load),     32'd1);
    chk("ct2_wr_addr",  32'(ram_addr),     32'(wr_model % int'(DEPTH)));
    exp_q.push_back(4'h4);
    wr_model++;
    tick();
    sif.in_valid = 1'b0;
    wait_drain();

    // 6: reset with a read in flight
    sif.out_ready = 1'b0;
    for (int d = 1; d <= 7; d++) push(DW'(d));
    repeat (2) tick();
    sif.out_ready = 1'b1;
    tick();
    chk("pre_rst_level", 32'(level), 32'd6);
    sif.out_ready = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    wr_model = 0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(sif.out_valid), 32'd0);
    chk("rst2_level",     32'(level),         32'd0);
    chk("rst2_empty",     32'(empty),         32'd1);
    chk("rst2_out_data",  32'(sif.out_data),  32'd0);
    tick();
    #1;
    chk("rst2_ignored", 32'(sif.out_valid), 32'd0);
    tick();
    sif.out_ready = 1'b1;
    push(4'h5);
    wait_drain();

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
